// File: rtl/data_mem_sram_ctrl.sv
// MEM-stage data memory controller for a 16-bit asynchronous SRAM.
// Each 32-bit access runs as a low and a high half-word phase of WAIT_CYCLES clocks.
module data_mem_sram_ctrl #(
  parameter logic [31:0] BASE        = 32'd1024,
  parameter int          ADDR_W      = 18,
  parameter int          WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_en,
  input  logic              wr_en,
  input  logic [31:0]       address,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              ready,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [15:0]       sram_dq_out,
  input  logic [15:0]       sram_dq_in,
  output logic              sram_dq_oe,
  output logic              sram_we_n
);

  typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

  localparam logic [3:0] LAST = 4'(WAIT_CYCLES - 1);

  state_t            state;
  logic [3:0]        count;
  logic [ADDR_W-2:0] word_lat;
  logic [15:0]       wdata_hi;
  logic              wr_lat;
  logic [15:0]       low_half;

  logic [31:0] mapped;
  logic        last;
  logic        unused_bits;

  assign mapped      = address - BASE;
  assign last        = (count == LAST);
  assign unused_bits = ^{mapped[31:ADDR_W+1], mapped[1:0]};
  assign ready       = ((state == IDLE) && !rd_en && !wr_en) || (state == DONE);

  // Outputs are registered one step ahead so they line up with the state they belong to;
  // WE rises on the last count of each phase while address and data stay put.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      count       <= '0;
      word_lat    <= '0;
      wdata_hi    <= '0;
      wr_lat      <= 1'b0;
      low_half    <= '0;
      rdata       <= '0;
      sram_addr   <= '0;
      sram_dq_out <= '0;
      sram_dq_oe  <= 1'b0;
      sram_we_n   <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (rd_en || wr_en) begin
            word_lat    <= mapped[ADDR_W:2];
            wdata_hi    <= wdata[31:16];
            wr_lat      <= wr_en;
            count       <= '0;
            state       <= LOW;
            sram_addr   <= {mapped[ADDR_W:2], 1'b0};
            sram_dq_out <= wdata[15:0];
            sram_dq_oe  <= wr_en;
            sram_we_n   <= ~wr_en;
          end
        end
        LOW: begin
          if (last) begin
            count       <= '0;
            state       <= HIGH;
            sram_addr   <= {word_lat, 1'b1};
            sram_dq_out <= wdata_hi;
            sram_we_n   <= ~wr_lat;
            if (!wr_lat) low_half <= sram_dq_in;
          end else begin
            count     <= count + 4'd1;
            sram_we_n <= ~wr_lat || (count + 4'd1 == LAST);
          end
        end
        HIGH: begin
          if (last) begin
            count      <= '0;
            state      <= DONE;
            sram_dq_oe <= 1'b0;
            sram_we_n  <= 1'b1;
            if (!wr_lat) rdata <= {sram_dq_in, low_half};
          end else begin
            count     <= count + 4'd1;
            sram_we_n <= ~wr_lat || (count + 4'd1 == LAST);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_sram_ctrl.sv
// Bench for data_mem_sram_ctrl: directed cases then random accesses against a word-level
// reference memory, with an asynchronous SRAM device model on the pins.
module tb_data_mem_sram_ctrl;

  localparam int          W      = 2;
  localparam int          ADDR_W = 18;
  localparam logic [31:0] BASE   = 32'd1024;

  logic              clk = 1'b0;
  logic              rst;
  logic              rd_en, wr_en;
  logic [31:0]       address, wdata;
  logic [31:0]       rdata;
  logic              ready;
  logic [ADDR_W-1:0] sram_addr;
  logic [15:0]       sram_dq_out, sram_dq_in;
  logic              sram_dq_oe, sram_we_n;

  data_mem_sram_ctrl #(.BASE(BASE), .ADDR_W(ADDR_W), .WAIT_CYCLES(W)) dut (
    .clk(clk), .rst(rst), .rd_en(rd_en), .wr_en(wr_en), .address(address), .wdata(wdata),
    .rdata(rdata), .ready(ready), .sram_addr(sram_addr), .sram_dq_out(sram_dq_out),
    .sram_dq_in(sram_dq_in), .sram_dq_oe(sram_dq_oe), .sram_we_n(sram_we_n)
  );

  always #5 clk = ~clk;

  // Asynchronous SRAM: read data follows the address, writes land on the rising WE edge.
  logic [15:0] sram_mem [0:(1<<ADDR_W)-1];
  assign sram_dq_in = sram_mem[sram_addr];
  always @(posedge sram_we_n) begin
    if (sram_dq_oe === 1'b1) sram_mem[sram_addr] <= sram_dq_out;
  end

  // Reference: 32-bit words indexed by word number; unwritten words read as zero.
  logic [31:0] ref_mem [int];
  logic [31:0] exp_rdata;
  bit          rdata_known;
  int          checks = 0;
  int          errors = 0;

  function automatic int word_of(input logic [31:0] a);
    logic [31:0] m;
    m = a - BASE;
    return int'((m >> 2) % (32'd1 << (ADDR_W - 1)));
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One access. b2b: issued at the DONE edge of the previous access so it starts in the
  // very next IDLE cycle; otherwise one idle cycle is left first. Returns at the DONE cycle.
  task automatic access(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d,
                        input bit b2b, input bit chk_data);
    int n, we_low, oe_cnt, wi;
    logic [ADDR_W-1:0] lo;
    bit done;
    wi = word_of(a);
    lo = ADDR_W'(wi * 2);
    if (!b2b) begin
      @(negedge clk);
      chk("ready_idle", {31'd0, ready}, 32'd1);
    end
    rd_en = rd; wr_en = wr; address = a; wdata = d;
    if (b2b) @(negedge clk); else #1;
    chk("ready_c0", {31'd0, ready}, 32'd0);
    n = 0; we_low = 0; oe_cnt = 0; done = 0;
    while (!done && n < 4 * W + 10) begin
      @(negedge clk);
      n++;
      if (sram_we_n === 1'b0) we_low++;
      if (sram_dq_oe === 1'b1) oe_cnt++;
      if (n == 1) begin
        chk("addr_lo", {14'd0, sram_addr}, {14'd0, lo});
        if (wr) chk("dq_lo", {16'd0, sram_dq_out}, {16'd0, d[15:0]});
      end
      if (n == W + 1) begin
        chk("addr_hi", {14'd0, sram_addr}, {14'd0, lo + 1'b1});
        if (wr) chk("dq_hi", {16'd0, sram_dq_out}, {16'd0, d[31:16]});
      end
      if (ready === 1'b1) done = 1;
    end
    chk("latency", n, 2 * W + 1);
    chk("we_low_cycles", we_low, wr ? 2 * (W - 1) : 0);
    chk("oe_cycles", oe_cnt, wr ? 2 * W : 0);
    if (wr) begin
      ref_mem[wi] = d;
      if (rdata_known) chk("rdata_hold", rdata, exp_rdata);
    end else if (chk_data) begin
      exp_rdata   = ref_mem.exists(wi) ? ref_mem[wi] : 32'd0;
      rdata_known = 1;
      chk("rdata", rdata, exp_rdata);
    end else begin
      rdata_known = 0;
    end
    $display("access %s addr=%h wdata=%h rdata=%h latency=%0d", wr ? "WR" : "RD", a, d, rdata, n);
    rd_en = 0; wr_en = 0;
  endtask

  initial begin
    bit rd, wr, b2b;
    int op;
    logic [31:0] a;
    for (int i = 0; i < (1 << ADDR_W); i++) sram_mem[i] = 16'd0;
    rst = 1; rd_en = 0; wr_en = 0; address = 0; wdata = 0;
    exp_rdata = 0; rdata_known = 1;
    repeat (3) @(negedge clk);
    rst = 0;
    @(negedge clk);
    chk("rst_ready", {31'd0, ready}, 32'd1);
    chk("rst_we_n", {31'd0, sram_we_n}, 32'd1);
    chk("rst_oe", {31'd0, sram_dq_oe}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_addr", {14'd0, sram_addr}, 32'd0);
    $display("reset done");

    access(0, 1, 32'd1028, 32'hDEADBEEF, 0, 1);
    access(1, 0, 32'd1028, 32'h0, 0, 1);
    access(0, 1, 32'd1032, 32'hCAFEF00D, 0, 1);
    access(1, 0, 32'd1024, 32'h0, 0, 1);
    access(1, 0, 32'd1028, 32'h0, 1, 1);
    access(1, 1, 32'd1024, 32'h12345678, 0, 1);
    chk("both_lo_half", {16'd0, sram_mem[0]}, 32'h5678);
    chk("both_hi_half", {16'd0, sram_mem[1]}, 32'h1234);
    access(1, 0, 32'd1024, 32'h0, 0, 1);

    // Abort a write in its HIGH phase with reset.
    @(negedge clk);
    rd_en = 0; wr_en = 1; address = 32'd1036; wdata = 32'hA5A55A5A;
    repeat (W + 2) @(negedge clk);
    rst = 1; wr_en = 0;
    @(negedge clk);
    rst = 0;
    #1;
    chk("abort_ready", {31'd0, ready}, 32'd1);
    chk("abort_we_n", {31'd0, sram_we_n}, 32'd1);
    chk("abort_oe", {31'd0, sram_dq_oe}, 32'd0);
    chk("abort_rdata", rdata, 32'd0);
    $display("reset during write to %h", 32'd1036);
    exp_rdata = 0; rdata_known = 1;
    ref_mem.delete(word_of(32'd1036));
    access(1, 0, 32'd1036, 32'h0, 0, 0);
    access(0, 1, 32'd1036, 32'h0BADC0DE, 0, 1);
    access(1, 0, 32'd1036, 32'h0, 1, 1);

    for (int i = 0; i < 30; i++) begin
      op  = int'($urandom_range(0, 2));
      rd  = (op != 1);
      wr  = (op != 0);
      b2b = $urandom_range(0, 1) == 1;
      if ($urandom_range(0, 4) == 0) a = BASE - 32'd4 * $urandom_range(1, 3) + $urandom_range(0, 3);
      else a = BASE + 32'd4 * $urandom_range(0, 15) + $urandom_range(0, 3);
      access(rd, wr, a, $urandom, b2b, 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
